// File: rtl/fetch_ifid_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Sequencer states: IDLE -> FETCH <-> HOLD / KILL. A one-entry holding
// register lets a fetch complete while decode is stalled. KILL waits out an
// in-flight access after a redirect and then discards its data.
// Optional build macro FETCH_STATS_EN adds FetchCount / FlushCount outputs.
//
// Handshake: ImemReq/ImemReady. An access completes at the rising edge where
// ImemReq and ImemReady are both high, and ImemRdata is sampled there.
// ImemAddr is held stable from the first cycle of ImemReq until it completes.
// ImemReady may already be high in the first request cycle (zero wait).
module fetch_ifid_unit (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] IFIDPC,
    output logic [31:0] IFIDIR,
    output logic        IFIDValid,
    output logic [1:0]  FsmState
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [15:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } fetchState_t;

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] killTarget;
    logic [31:0] holdIr;
    logic [31:0] holdPc;
    logic        holdValid;
    logic        rstSync;
    logic [31:0] pcPlus4;
    logic [31:0] tgtAligned;

    // Low two target bits are forced to zero; PC+4 wraps naturally at 2^32.
    assign tgtAligned = BranchTarget & ~32'd3;
    assign pcPlus4    = pc + 32'd4;

    // The memory is requested only while fetching or draining a killed access.
    assign ImemReq  = (state == FETCH) || (state == KILL);
    assign ImemAddr = pc;
    assign FsmState = state;

    // Sequencer, PC, holding register and IF/ID register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            pc         <= 32'd0;
            killTarget <= 32'd0;
            holdIr     <= 32'd0;
            holdPc     <= 32'd0;
            holdValid  <= 1'b0;
            rstSync    <= 1'b0;
            IFIDPC     <= 32'd0;
            IFIDIR     <= 32'd0;
            IFIDValid  <= 1'b0;
        end else begin
            // rstSync rises one edge after release so IDLE is left synchronously.
            rstSync <= 1'b1;
            // A redirect always bubbles IF/ID and drops any held word.
            if (BranchTaken) begin
                IFIDPC    <= 32'd0;
                IFIDIR    <= 32'd0;
                IFIDValid <= 1'b0;
                holdValid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (BranchTaken) pc <= tgtAligned;
                    if (rstSync) state <= FETCH;
                end
                FETCH: begin
                    if (BranchTaken) begin
                        if (ImemReady) begin
                            pc <= tgtAligned;
                        end else begin
                            killTarget <= tgtAligned;
                            state      <= KILL;
                        end
                    end else if (ImemReady) begin
                        pc <= pcPlus4;
                        if (Stall) begin
                            holdIr    <= ImemRdata;
                            holdPc    <= pcPlus4;
                            holdValid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            IFIDIR    <= ImemRdata;
                            IFIDPC    <= pcPlus4;
                            IFIDValid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (BranchTaken) begin
                        pc    <= tgtAligned;
                        state <= FETCH;
                    end else if (!Stall) begin
                        IFIDIR    <= holdIr;
                        IFIDPC    <= holdPc;
                        IFIDValid <= holdValid;
                        holdValid <= 1'b0;
                        state     <= FETCH;
                    end
                end
                KILL: begin
                    // The latest redirect wins; the old access data is dropped.
                    if (BranchTaken) killTarget <= tgtAligned;
                    if (ImemReady) begin
                        pc    <= BranchTaken ? tgtAligned : killTarget;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic ifidLoad;

    assign ifidLoad = !BranchTaken && !Stall &&
                      (((state == FETCH) && ImemReady) ||
                       ((state == HOLD) && holdValid));

    // Counts valid IF/ID loads and redirects (the latter saturating).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            FetchCount <= 32'd0;
            FlushCount <= 16'd0;
        end else begin
            if (ifidLoad) FetchCount <= FetchCount + 32'd1;
            if (BranchTaken && (FlushCount != 16'hFFFF)) FlushCount <= FlushCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_ifid_unit.md
FETCH_IFID_UNIT -- requirements
Module: fetch_ifid_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 Stall  input  1  decode hazard hold; IF/ID SHALL keep its contents while high.
REQ-005 BranchTaken  input  1  one-cycle redirect pulse from decode.
REQ-006 BranchTarget  input  32  redirect address; bits [1:0] SHALL be ignored and treated as 0.
REQ-007 ImemReq  output  1  instruction-memory request.
REQ-008 ImemAddr  output  32  word-aligned fetch address; SHALL equal PC.
REQ-009 ImemReady  input  1  access complete; may be high in the same cycle as ImemReq (zero-wait).
REQ-010 ImemRdata  input  32  instruction word, valid when ImemReq and ImemReady are both high.
REQ-011 IFIDPC  output  32  PC+4 of the instruction held in IF/ID.
REQ-012 IFIDIR  output  32  instruction held in IF/ID.
REQ-013 IFIDValid  output  1  IF/ID holds a real instruction, not a bubble.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, HOLD and KILL.
REQ-015 IDLE SHALL last one cycle after reset release, then go to FETCH with ImemReq=0 while in IDLE.
REQ-016 FETCH SHALL drive ImemReq=1 and keep ImemAddr stable until ImemReady=1.
REQ-017 FETCH with ImemReady=1, Stall=0 and BranchTaken=0: at the edge, IFIDIR<=ImemRdata, IFIDPC<=PC+4, IFIDValid<=1, PC<=PC+4, state stays FETCH (one instruction per cycle at zero wait).
REQ-018 FETCH with ImemReady=1 and Stall=1: the word and PC+4 SHALL go to a one-entry holding register, PC<=PC+4, and state SHALL go to HOLD; IF/ID is unchanged.
REQ-019 HOLD SHALL drive ImemReq=0; when Stall falls, IF/ID SHALL load from the holding register and state SHALL return to FETCH.
REQ-020 BranchTaken SHALL have priority over Stall and over any completing fetch: IFIDValid<=0, IFIDIR<=0, IFIDPC<=0, holding register invalidated, PC<=BranchTarget.
REQ-021 Redirect state rules:
- In FETCH with ImemReady=1, or in HOLD or IDLE: next state SHALL be FETCH at the target.
- In FETCH with ImemReady=0: next state SHALL be KILL.
REQ-022 KILL SHALL keep ImemReq=1 on the old address until ImemReady=1, discard that data, then go to FETCH at the target.
REQ-023 A second BranchTaken while in KILL SHALL overwrite the pending target; the last target wins.
REQ-024 PC+4 SHALL wrap modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
REQ-025 IFIDValid SHALL be 0 while IF/ID holds a bubble; downstream SHALL treat IFIDIR=0 as a nop.

Reset
REQ-026 On Rst_n=0, immediately and regardless of Clk: PC=0x00000000, state=IDLE, ImemReq=0, IFIDIR=0, IFIDPC=0, IFIDValid=0, holding register invalid.
REQ-027 Reset asserted mid-access SHALL abandon the access; no late ImemReady SHALL load IF/ID.
REQ-028 Reset release SHALL be synchronised to Clk before it leaves IDLE.

Configuration
REQ-029 Macro FETCH_STATS_EN, when defined, SHALL add outputs FetchCount (32) and FlushCount (16).
- FetchCount: increments on every IF/ID load with IFIDValid becoming 1.
- FlushCount: increments on every BranchTaken; saturates at 0xFFFF.
- Both reset to 0.
REQ-030 Without FETCH_STATS_EN the counters and their ports SHALL NOT exist and behaviour SHALL be otherwise identical.

Verification
REQ-031 Reset release, ImemReady tied 1, Rdata = address -> IFIDIR = 0,4,8,12 on consecutive cycles; IFIDPC = 4,8,12,16.
REQ-032 ImemReady held low 3 cycles at PC=0x10 -> ImemAddr stays 0x10 and IFIDValid unchanged; IF/ID loads on the 4th cycle.
REQ-033 Stall high for 2 cycles while a fetch completes -> IF/ID frozen, state HOLD, ImemReq=0; held word appears in IF/ID one edge after Stall falls; no word lost or duplicated.
REQ-034 BranchTaken to 0x200 with an access pending (ImemReady=0) -> IFIDValid=0, the old word is discarded when it arrives, and the next ImemAddr is 0x200.
REQ-035 BranchTaken and Stall together, then PC at 0xFFFFFFFC with ImemReady=1 -> the branch flushes IF/ID and wins over Stall; the next address after 0xFFFFFFFC is 0x00000000.
REQ-036 Rst_n pulsed low mid-access -> all outputs at reset values asynchronously; with FETCH_STATS_EN, counters read 0.
